// File: rtl/int_sched_pkg.sv
// Shared definitions for the interrupt scheduler: default register map,
// FSM state encoding and the vector address helper.
package int_sched_pkg;

   localparam logic [7:0] ADDR_VBASE_DEF = 8'd250;
   localparam logic [7:0] ADDR_MASK_DEF  = 8'd249;
   localparam logic [7:0] ADDR_PEND_DEF  = 8'd248;
   localparam logic [7:0] ADDR_EOI_DEF   = 8'd247;

   localparam int VEC_STRIDE_SHIFT = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   // Handler entries are 4 bytes apart; the sum wraps modulo 256.
   function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [2:0] id);
      return base + (8'(id) << VEC_STRIDE_SHIFT);
   endfunction

endpackage

// File: rtl/int_sched_if.sv
// CPU-side bus of the interrupt scheduler: register access port, source
// lines and the interrupt request/acknowledge pair.
interface int_sched_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0] src;
   logic [7:0]       addr;
   logic [7:0]       w_data;
   logic             w_en;
   logic [7:0]       r_data;
   logic             r_hit;
   // Handshake: int_req stays high with int_vec stable until the CPU pulses
   // int_ack for one cycle; an ack seen while int_req is low is ignored.
   logic             int_ack;
   logic             int_req;
   logic             int_en;
   logic [7:0]       int_vec;

   modport master (
      output src, addr, w_data, w_en, int_ack,
      input  r_data, r_hit, int_req, int_en, int_vec
   );

   modport slave (
      input  src, addr, w_data, w_en, int_ack,
      output r_data, r_hit, int_req, int_en, int_vec
   );
endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: id_o is the lowest set bit of req_i.
module int_prio_enc #(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req_i,
   output logic [2:0]       id_o,
   output logic             valid_o
);

   always_comb begin
      id_o    = '0;
      valid_o = |req_i;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) id_o = 3'(i);
      end
   end

endmodule

// File: rtl/int_sched.sv
// Memory-mapped interrupt controller: latches source rising edges, picks one
// by fixed priority and runs a request -> ack -> EOI sequence with the CPU.
module int_sched
   import int_sched_pkg::*;
#(
   parameter int         N_SRC      = 4,
   parameter logic [7:0] ADDR_VBASE = ADDR_VBASE_DEF,
   parameter logic [7:0] ADDR_MASK  = ADDR_MASK_DEF,
   parameter logic [7:0] ADDR_PEND  = ADDR_PEND_DEF,
   parameter logic [7:0] ADDR_EOI   = ADDR_EOI_DEF
) (
   input  logic        clock,
   input  logic        reset,
   int_sched_if.slave  bus,
   output state_e      dbg_state_o
);

   logic [N_SRC-1:0] src_q, pend_q, pend_d, mask_q, mask_d;
   logic [N_SRC-1:0] edge_w, clr_w, act_onehot, elig;
   logic [7:0]       vbase_q;
   logic [2:0]       act_id_q, sel_id;
   logic             sel_valid, act_live;
   state_e           state_q;
   logic             int_req_q, int_en_q;
   logic [7:0]       int_vec_q;
   logic             wr_vbase, wr_mask, wr_pend, wr_eoi;

   assign wr_vbase = bus.w_en && (bus.addr == ADDR_VBASE);
   assign wr_mask  = bus.w_en && (bus.addr == ADDR_MASK);
   assign wr_pend  = bus.w_en && (bus.addr == ADDR_PEND);
   assign wr_eoi   = bus.w_en && (bus.addr == ADDR_EOI);

   // Set beats clear in pend_d so an edge coinciding with ack or W1C is kept.
   always_comb begin
      edge_w     = bus.src & ~src_q;
      act_onehot = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (act_id_q == 3'(i)) act_onehot[i] = 1'b1;
      end
      clr_w = (wr_pend ? bus.w_data[N_SRC-1:0] : '0)
            | ((state_q == ST_REQ && bus.int_ack) ? act_onehot : '0);
      pend_d   = (pend_q & ~clr_w) | edge_w;
      mask_d   = wr_mask ? bus.w_data[N_SRC-1:0] : mask_q;
      act_live = |(act_onehot & pend_d & mask_d);
      elig     = pend_q & mask_q;
   end

   int_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req_i   (elig),
      .id_o    (sel_id),
      .valid_o (sel_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         src_q   <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         vbase_q <= '0;
      end else begin
         src_q  <= bus.src;
         pend_q <= pend_d;
         mask_q <= mask_d;
         if (wr_vbase) vbase_q <= bus.w_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         act_id_q  <= '0;
         int_req_q <= 1'b0;
         int_en_q  <= 1'b1;
         int_vec_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_valid) begin
                  act_id_q  <= sel_id;
                  int_vec_q <= vec_addr(vbase_q, sel_id);
                  int_req_q <= 1'b1;
                  int_en_q  <= 1'b1;
                  state_q   <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A mask-off or W1C of the active source withdraws the request.
               if (bus.int_ack) begin
                  int_req_q <= 1'b0;
                  int_en_q  <= 1'b0;
                  state_q   <= ST_SERVICE;
               end else if (!act_live) begin
                  int_req_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (wr_eoi) begin
                  int_en_q <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               int_req_q <= 1'b0;
               int_en_q  <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.r_data = '0;
      bus.r_hit  = 1'b0;
      if (bus.addr == ADDR_VBASE) begin
         bus.r_hit  = 1'b1;
         bus.r_data = vbase_q;
      end else if (bus.addr == ADDR_MASK) begin
         bus.r_hit  = 1'b1;
         bus.r_data = 8'(mask_q);
      end else if (bus.addr == ADDR_PEND) begin
         bus.r_hit  = 1'b1;
         bus.r_data = 8'(pend_q);
      end else if (bus.addr == ADDR_EOI) begin
         bus.r_hit  = 1'b1;
         bus.r_data = {5'b0, act_id_q};
      end
   end

   assign bus.int_req = int_req_q;
   assign bus.int_en  = int_en_q;
   assign bus.int_vec = int_vec_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_int_sched;
   import int_sched_pkg::*;

   localparam int         N     = 4;
   localparam logic [7:0] A_VB  = 8'd250;
   localparam logic [7:0] A_MK  = 8'd249;
   localparam logic [7:0] A_PD  = 8'd248;
   localparam logic [7:0] A_EOI = 8'd247;

   logic   clock = 1'b0;
   logic   reset = 1'b1;
   state_e dbg_state;

   int_sched_if #(.N_SRC(N)) bus ();

   int_sched #(.N_SRC(N)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];
   string       tag_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic expect_val(input string tag, input logic [15:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic chk(input logic [15:0] obs);
      logic [15:0] e;
      string       t;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty observed=%0h expected=<none>", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.addr   = a;
      bus.w_data = d;
      bus.w_en   = 1'b1;
      tick();
      bus.w_en   = 1'b0;
      bus.addr   = 8'd0;
      bus.w_data = 8'd0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic hit);
      bus.addr = a;
      #1;
      d        = bus.r_data;
      hit      = bus.r_hit;
      bus.addr = 8'd0;
   endtask

   task automatic ack();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] d;
      logic       h;
      bus.src     = '0;
      bus.addr    = 8'd0;
      bus.w_data  = 8'd0;
      bus.w_en    = 1'b0;
      bus.int_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      expect_val("rst_req", 16'd0);   chk(16'(bus.int_req));
      expect_val("rst_en", 16'd1);    chk(16'(bus.int_en));
      expect_val("rst_vec", 16'h00);  chk(16'(bus.int_vec));
      expect_val("rst_state", 16'd0); chk(16'(dbg_state));
      rd(A_PD, d, h);
      expect_val("rst_pend", 16'h00); chk(16'(d));
      expect_val("rst_pend_hit", 16'd1); chk(16'(h));
      rd(8'd246, d, h);
      expect_val("miss_data", 16'h00); chk(16'(d));
      expect_val("miss_hit", 16'd0);   chk(16'(h));

      // T1: single source, vbase 0x80
      wr(A_VB, 8'h80);
      wr(A_MK, 8'h04);
      rd(A_VB, d, h);
      expect_val("t1_vbase", 16'h80); chk(16'(d));
      rd(A_MK, d, h);
      expect_val("t1_mask", 16'h04);  chk(16'(d));
      bus.src = 4'b0100;
      expect_val("t1_pend", 16'h04);
      expect_val("t1_req_early", 16'd0);
      tick();
      rd(A_PD, d, h); chk(16'(d));
      chk(16'(bus.int_req));
      expect_val("t1_req", 16'd1);
      expect_val("t1_vec", 16'h88);
      expect_val("t1_state_req", 16'd1);
      tick();
      chk(16'(bus.int_req)); chk(16'(bus.int_vec)); chk(16'(dbg_state));
      expect_val("t1_ack_req", 16'd0);
      expect_val("t1_ack_en", 16'd0);
      expect_val("t1_ack_pend", 16'h00);
      expect_val("t1_eoi_rd", 16'h02);
      ack();
      chk(16'(bus.int_req)); chk(16'(bus.int_en));
      rd(A_PD, d, h); chk(16'(d));
      rd(A_EOI, d, h); chk(16'(d));
      bus.src = '0;
      expect_val("t1_eoi_en", 16'd1);
      expect_val("t1_eoi_state", 16'd0);
      wr(A_EOI, 8'h5A);
      chk(16'(bus.int_en)); chk(16'(dbg_state));

      // T2: simultaneous edges on 3 and 1
      wr(A_MK, 8'h0F);
      bus.src = 4'b1010;
      expect_val("t2_vec_id1", 16'h84);
      expect_val("t2_vec_id3", 16'h8C);
      expect_val("t2_act_id3", 16'h03);
      tick();
      tick();
      chk(16'(bus.int_vec));
      ack();
      wr(A_EOI, 8'h00);
      tick();
      chk(16'(bus.int_vec));
      rd(A_EOI, d, h); chk(16'(d));
      ack();
      wr(A_EOI, 8'h00);
      bus.src = '0;

      // T3: no nesting while in service
      bus.src = 4'b0100;
      tick();
      tick();
      expect_val("t3_vec_id2", 16'h88); chk(16'(bus.int_vec));
      ack();
      bus.src = 4'b0101;
      tick();
      expect_val("t3_svc_req0", 16'd0); chk(16'(bus.int_req));
      tick();
      expect_val("t3_svc_req1", 16'd0); chk(16'(bus.int_req));
      expect_val("t3_svc_en", 16'd0);   chk(16'(bus.int_en));
      wr(A_EOI, 8'h00);
      expect_val("t3_eoi_req", 16'd0);  chk(16'(bus.int_req));
      tick();
      expect_val("t3_id0_req", 16'd1);  chk(16'(bus.int_req));
      expect_val("t3_id0_vec", 16'h80); chk(16'(bus.int_vec));
      ack();
      wr(A_EOI, 8'h00);
      bus.src = '0;

      // T4: vector wrap, vbase write while latched, W1C withdraw
      wr(A_VB, 8'hF8);
      bus.src = 4'b1000;
      tick();
      tick();
      expect_val("t4_wrap_vec", 16'h04); chk(16'(bus.int_vec));
      expect_val("t4_wrap_req", 16'd1);  chk(16'(bus.int_req));
      wr(A_VB, 8'h00);
      expect_val("t4_vec_hold", 16'h04); chk(16'(bus.int_vec));
      wr(A_PD, 8'h08);
      expect_val("t4_wd_req", 16'd0);    chk(16'(bus.int_req));
      expect_val("t4_wd_state", 16'd0);  chk(16'(dbg_state));
      rd(A_PD, d, h);
      expect_val("t4_wd_pend", 16'h00);  chk(16'(d));
      bus.src = '0;

      // T5: held source, masked latching, ack vs new edge
      wr(A_MK, 8'h00);
      bus.src = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         expect_val("t5_masked_req", 16'd0);
         tick();
         chk(16'(bus.int_req));
      end
      rd(A_PD, d, h);
      expect_val("t5_pend_held", 16'h02); chk(16'(d));
      wr(A_PD, 8'h02);
      tick();
      tick();
      rd(A_PD, d, h);
      expect_val("t5_once", 16'h00);      chk(16'(d));
      bus.src = '0;
      tick();
      bus.src = 4'b0010;
      tick();
      wr(A_MK, 8'h02);
      expect_val("t5_mask_edge_req", 16'd0); chk(16'(bus.int_req));
      tick();
      expect_val("t5_unmask_req", 16'd1); chk(16'(bus.int_req));
      expect_val("t5_unmask_vec", 16'h04); chk(16'(bus.int_vec));
      bus.src = '0;
      tick();
      expect_val("t5_req_hold", 16'd1);   chk(16'(bus.int_req));
      bus.src = 4'b0010;
      ack();
      expect_val("t5_svc_state", 16'd2);  chk(16'(dbg_state));
      rd(A_PD, d, h);
      expect_val("t5_set_wins", 16'h02);  chk(16'(d));

      // reset during service
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_val("r2_req", 16'd0);   chk(16'(bus.int_req));
      expect_val("r2_en", 16'd1);    chk(16'(bus.int_en));
      expect_val("r2_vec", 16'h00);  chk(16'(bus.int_vec));
      expect_val("r2_state", 16'd0); chk(16'(dbg_state));
      rd(A_PD, d, h);
      expect_val("r2_pend", 16'h00); chk(16'(d));
      rd(A_MK, d, h);
      expect_val("r2_mask", 16'h00); chk(16'(d));
      rd(A_EOI, d, h);
      expect_val("r2_act", 16'h00);  chk(16'(d));
      rd(A_VB, d, h);
      expect_val("r2_vbase", 16'h00); chk(16'(d));

      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Memory-mapped interrupt controller for the 8-bit CPU subsystem.
- Collects up to N_SRC interrupt sources (UART rx, UART tx-done, timer, GPIO, ...) and latches their rising edges as pending.
- Selects one source by fixed priority and drives the CPU's int_req/int_en/int_vec.
- Sequences a request -> acknowledge -> end-of-interrupt handshake, so only one handler runs at a time.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- ADDR_VBASE, 8'd250, address of the vector base register (R/W).
- ADDR_MASK, 8'd249, address of the enable mask (R/W; bit i = 1 enables source i).
- ADDR_PEND, 8'd248, address of the pending register (R; write-1-to-clear).
- ADDR_EOI, 8'd247, address of the end-of-interrupt register (W, data ignored; R returns the active source id).

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- src  in  N_SRC  level interrupt sources; rising edge requests service.
- addr  in  8  CPU data address (rs_data).
- w_data  in  8  CPU store data (rd_data).
- w_en  in  1  CPU store strobe (mem_w_en).
- r_data  out  8  read data for a decoded address; 0 otherwise.
- r_hit  out  1  addr matches one of the four registers; top-level read-mux select.
- int_ack  in  1  one-cycle pulse from the CPU when it vectors to the handler.
- int_req  out  1  interrupt request to the CPU.
- int_en  out  1  CPU interrupt enable (1 = CPU may take int_req).
- int_vec  out  8  handler address for the selected source.

Behaviour:
- Reset values (applied on any clock edge with reset=1, including mid-handler):
  - src_q = 0, pend = 0, mask = 0, vbase = 0, state = IDLE, act_id = 0.
  - Outputs: int_req = 0, int_en = 1, int_vec = 0.
- Edge capture:
  - src_q <= src every cycle.
  - edge = src & ~src_q; pend <= (pend & ~clr) | edge.
  - Set wins over clear on the same bit in the same cycle, so no edge is lost.
  - A held-high source produces exactly one pend set.
  - Pending bits latch regardless of mask.
- Eligibility: elig = pend & mask. Selection is fixed priority, lowest index highest; sel_id is the lowest set bit of elig.
- State machine (states: IDLE, REQ, SERVICE):
  - IDLE: if elig != 0, latch act_id <= sel_id and int_vec <= vbase + {act_id, 2'b00} (8-bit add, wraps mod 256). Go to REQ; int_req goes high on that same edge (registered).
  - REQ: int_req = 1, int_en = 1, int_vec held stable.
    - int_ack = 1: clear pend[act_id], int_req <= 0, int_en <= 0, go to SERVICE.
    - act_id masked off or cleared via PEND write before ack: int_req <= 0, go to IDLE (request withdrawn).
  - SERVICE: int_req = 0, int_en = 0. Newer or higher-priority requests stay pending (no nesting).
    - Write to ADDR_EOI: int_en <= 1, go to IDLE.
    - Re-arbitration happens in IDLE the next cycle.
  - int_ack outside REQ is ignored.
- Latency: src rises before edge k -> pend set after edge k -> int_req high after edge k+1 when IDLE and enabled. Minimum gap from EOI to the next int_req is 2 edges.
- Register writes (w_en=1 and addr match, applied on clock):
  - VBASE <= w_data.
  - MASK <= w_data[N_SRC-1:0].
  - PEND: clr = w_data bits set.
  - EOI: as above.
  - Writes to non-matching addresses have no effect.
- Register reads (combinational):
  - VBASE reads vbase.
  - MASK and PEND read zero-extended to 8 bits.
  - EOI reads {5'b0, act_id}.
  - r_hit = 1 only for these four addresses.
- A VBASE write during REQ/SERVICE does not change the already-latched int_vec.

Decomposition:
- Package int_sched_pkg: default register addresses, state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), VEC_STRIDE_SHIFT=2.
- Sub-module int_prio_enc: combinational lowest-index-first priority encoder, N_SRC-bit input -> 3-bit id plus valid.

Test Plan:
- Reset, write VBASE=8'h80, MASK=4'b0100, raise src[2] -> pend=4'b0100, int_req high 2 edges later, int_vec=8'h88; int_ack -> int_req=0, int_en=0, pend=0; EOI write -> int_en=1.
- MASK=4'hF, src[3] and src[1] rise same cycle -> int_vec selects id 1. After ack+EOI -> second request with id 3, int_vec=vbase+12.
- In SERVICE for id 2, src[0] rises -> no int_req until EOI; then id 0 is requested 2 edges after the EOI write.
- VBASE=8'hF8, source 3 -> int_vec=8'h04 (wrap). PEND write 8'h08 while in REQ for id 3 -> int_req drops, state IDLE.
- src[1] held high 20 cycles with MASK=0 -> pend[1]=1 exactly once, no int_req. MASK=4'b0010 -> int_req. Ack in the same cycle as a new src[1] edge -> pend[1] stays 1.
- Assert reset during SERVICE -> next cycle int_req=0, int_en=1, pend=0, mask=0, r_data at ADDR_EOI=0.
